gpia_wb_port: RTL and testbench
===============================

Name: gpia_wb_port

Overview:
- Wishbone B3 classic 8-bit slave front-end for a bank of GPIA byte registers.
- Decodes bus address into a byte select and an operation mode (write / set / clear / toggle). Issues a single-cycle strobe, mode and data to the selected GPIA byte, and returns that byte's current output value on reads.
- Sits directly upstream of the GPIA byte registers, between the system bus and the per-byte clk_i/res_i/mode_i/d_i/stb_i/q_o interface.

Parameters:
- NBYTES, 2, number of GPIA bytes served (1..8).
- ADR_W, 3, width of adr_i. 2^(ADR_W-2) must be >= NBYTES, or >= NBYTES+1 when GPIA_WB_INPUT_EN is defined.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- res_i  in  1  reset, synchronous, active-low.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  Wishbone write enable.
- adr_i  in  ADR_W  [1:0] = mode, [ADR_W-1:2] = byte index.
- dat_i  in  8  write data.
- dat_o  out  8  read data, valid while ack_o is high.
- ack_o  out  1  Wishbone acknowledge.
- gpia_res_o  out  1  active-high reset to GPIA bytes; equals ~res_i (combinational).
- gpia_mode_o  out  2  operation mode to all GPIA bytes.
- gpia_d_o  out  8  data to all GPIA bytes.
- gpia_stb_o  out  NBYTES  one-hot strobe; bit n selects byte n.
- gpia_q_i  in  8*NBYTES  current GPIA outputs; byte n at [8n+7:8n].

Behaviour:
- Reset (res_i low at a rising edge): next-cycle values are ack_o=0, dat_o=0, gpia_stb_o=0, gpia_mode_o=0, gpia_d_o=0. Reset wins over any bus request in the same cycle. Reset mid-transfer aborts it: no ack, no strobe.
- State machine has two states:
  - IDLE: a request is cyc_i & stb_i sampled at an edge. On a request, go to ACK.
  - ACK: lasts exactly 1 cycle with ack_o=1, then returns to IDLE unconditionally. Requests are ignored while ack_o=1, so a master holding stb_i after ack starts a new transfer no earlier than the next edge.
- Latency: request sampled at edge E0; ack_o is high from E0 to E1. Wait states are fixed at zero beyond the registered ack.
- Write (we_i=1), byte index k < NBYTES:
  - At E0, register gpia_mode_o=adr_i[1:0], gpia_d_o=dat_i, gpia_stb_o=(1<<k).
  - gpia_stb_o is high for exactly one cycle; the GPIA byte updates q at E1.
  - gpia_mode_o and gpia_d_o hold their values until the next write.
- Read (we_i=0): at E0, dat_o = gpia_q_i byte k; mode bits are ignored. No strobe is issued. dat_o returns to 0 at E1.
- Out-of-range byte index: the transfer is still acked, writes produce no strobe, and reads return 0.
- Read-after-write coherency: a read sampled at E2 or later returns the post-write q.
- cyc_i low: stb_i is ignored.
- Master dropping stb_i before ack: not possible, because ack is registered at the first sampling edge; a one-cycle strobe gets a full transfer.
- No error or retry outputs.

Optional Feature:
- Macro: GPIA_WB_INPUT_EN.
- When defined, the block adds port pins_i (in, 8) and a two-flop synchronizer on pins_i; both flops reset to 0.
  - Byte index NBYTES reads the second synchronizer stage; mode bits are ignored.
  - Writes to that index are acked, with no strobe and no effect.
  - A pin change becomes readable at the third edge after it is stable.
- When undefined, pins_i and the synchronizer are absent, and index NBYTES behaves as out-of-range.

Test Plan:
1. Hold res_i=0 for 2 cycles, then release -> ack_o=0, gpia_stb_o=0, dat_o=0, gpia_res_o=1 during reset and 0 after.
2. Write adr={k=1, mode=0}, dat_i=3C -> ack_o high for exactly 1 cycle; gpia_stb_o=2'b10 for 1 cycle with gpia_mode_o=0 and gpia_d_o=3C; a subsequent read of byte 1 returns 3C.
3. Write FF to byte 0, then adr={0, mode=2} with dat_i=3C, then read byte 0 -> gpia_mode_o=2 on the strobe cycle; read returns C3. Repeat with mode=3 on FF -> C3; mode=1 on 00 -> 3C.
4. Master holds cyc_i/stb_i/we_i high for 4 cycles -> ack_o pattern 1,0,1,0 and exactly two strobes; never two consecutive strobe cycles.
5. Write byte index 3 with NBYTES=2 (feature off) -> acked; gpia_stb_o stays 0; read of index 3 returns 00. Assert res_i low on the cycle a request is sampled -> no ack, no strobe.
6. GPIA_WB_INPUT_EN defined: set pins_i=A5 -> a read of index 2 returns A5 when sampled at least 3 edges later and 00 when sampled 1 edge later; writing index 2 gives ack with no strobe.

Source files
------------

// File: rtl/gpia_wb_port.sv
// ---------------------------------------------------------------------------
// gpia_wb_port
//
// Wishbone B3 classic 8-bit slave front-end for a bank of GPIA byte
// registers. The bus address selects one GPIA byte (adr_i[ADR_W-1:2]) and an
// operation mode (adr_i[1:0]: write / set / clear / toggle). A write issues a
// single-cycle one-hot strobe together with the mode and data to the selected
// byte. A read returns that byte's current output value. Every transfer is
// acknowledged exactly one cycle after the request is sampled.
//
// Parameters:
//   NBYTES  number of GPIA bytes served (1..8)
//   ADR_W   width of adr_i; 2^(ADR_W-2) must cover every byte index in use
//
// Ports:
//   clk_i        system clock, rising edge
//   res_i        synchronous active-low reset
//   cyc_i        Wishbone cycle
//   stb_i        Wishbone strobe
//   we_i         Wishbone write enable
//   adr_i        [1:0] mode, [ADR_W-1:2] byte index
//   dat_i        write data
//   dat_o        read data, valid while ack_o is high, 0 otherwise
//   ack_o        Wishbone acknowledge
//   gpia_res_o   active-high reset to the GPIA bytes (~res_i)
//   gpia_mode_o  operation mode to all GPIA bytes
//   gpia_d_o     data to all GPIA bytes
//   gpia_stb_o   one-hot strobe, bit n selects byte n
//   gpia_q_i     GPIA outputs, byte n at [8n+7:8n]
//   pins_i       (only with GPIA_WB_INPUT_EN) asynchronous input pins
//
// Optional feature (macro GPIA_WB_INPUT_EN):
//   Adds pins_i and a two-flop synchronizer. Byte index NBYTES reads the
//   second synchronizer stage; writes to that index are acked and ignored.
//   Without the macro, index NBYTES is simply out of range.
// ---------------------------------------------------------------------------
module gpia_wb_port #(
  parameter int NBYTES = 2,
  parameter int ADR_W  = 3
) (
  input  logic                clk_i,
  input  logic                res_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [ADR_W-1:0]    adr_i,
  input  logic [7:0]          dat_i,
  output logic [7:0]          dat_o,
  output logic                ack_o,
  output logic                gpia_res_o,
  output logic [1:0]          gpia_mode_o,
  output logic [7:0]          gpia_d_o,
  output logic [NBYTES-1:0]   gpia_stb_o,
  input  logic [8*NBYTES-1:0] gpia_q_i
`ifdef GPIA_WB_INPUT_EN
  ,
  input  logic [7:0]          pins_i
`endif
);

  localparam int IDX_W = ADR_W - 2;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } GpiaState;

  GpiaState            r_state;
  GpiaState            w_stateNext;

  logic [7:0]          r_datO;
  logic [NBYTES-1:0]   r_stb;
  logic [1:0]          r_mode;
  logic [7:0]          r_d;

  logic [7:0]          w_datNext;
  logic [NBYTES-1:0]   w_stbNext;
  logic [1:0]          w_modeNext;
  logic [7:0]          w_dNext;

  logic                w_req;
  logic [IDX_W-1:0]    w_idx;
  logic                w_inRange;
  logic [7:0]          w_rdByte;
  logic                w_pinsHit;
  logic [7:0]          w_pinsByte;

  // The GPIA bytes share our reset, just with the opposite polarity.
  assign gpia_res_o = ~res_i;

  // A request is only meaningful with both cycle and strobe asserted; the
  // FSM additionally ignores it while the previous ack is still showing.
  assign w_req = cyc_i & stb_i;
  assign w_idx = adr_i[ADR_W-1:2];

  // Compare in 32 bits so that NBYTES == 2^IDX_W does not wrap to zero.
  assign w_inRange = (32'(w_idx) < NBYTES);

`ifdef GPIA_WB_INPUT_EN
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  // Two-flop synchronizer for the asynchronous input pins. A change that is
  // stable before edge N shows in r_sync2 after edge N+1, so a read sampled
  // at edge N+2 returns it.
  always_ff @(posedge clk_i) begin
    if (!res_i) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= pins_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pinsHit  = (32'(w_idx) == NBYTES);
  assign w_pinsByte = r_sync2;
`else
  // Without the input feature, index NBYTES falls into the out-of-range case.
  assign w_pinsHit  = 1'b0;
  assign w_pinsByte = 8'h00;
`endif

  // Read data mux: select the addressed GPIA byte, the synchronized pins, or
  // zero for any index that maps to nothing.
  always_comb begin
    w_rdByte = 8'h00;
    for (int n = 0; n < NBYTES; n++) begin
      if (32'(w_idx) == n) begin
        w_rdByte = gpia_q_i[8*n +: 8];
      end
    end
    if (w_pinsHit) begin
      w_rdByte = w_pinsByte;
    end
  end

  // FSM state register. Reset takes priority over any bus request in the
  // same cycle, which also aborts a transfer in progress.
  always_ff @(posedge clk_i) begin
    if (!res_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and next-output logic. A request seen in IDLE is answered in
  // the ACK state one cycle later; the strobe and read data are only ever
  // loaded on that single accepting edge, so they fall back to zero on the
  // edge that ends the ack. Mode and data hold until the next valid write so
  // the GPIA bytes see stable values around their strobe.
  always_comb begin
    w_stateNext = r_state;
    w_datNext   = 8'h00;
    w_stbNext   = '0;
    w_modeNext  = r_mode;
    w_dNext     = r_d;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_stateNext = ACK;
          if (we_i) begin
            if (w_inRange) begin
              w_stbNext  = NBYTES'(1) << w_idx;
              w_modeNext = adr_i[1:0];
              w_dNext    = dat_i;
            end
          end else begin
            w_datNext = w_rdByte;
          end
        end
      end
      ACK: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Registered bus and GPIA outputs.
  always_ff @(posedge clk_i) begin
    if (!res_i) begin
      r_datO <= 8'h00;
      r_stb  <= '0;
      r_mode <= 2'b00;
      r_d    <= 8'h00;
    end else begin
      r_datO <= w_datNext;
      r_stb  <= w_stbNext;
      r_mode <= w_modeNext;
      r_d    <= w_dNext;
    end
  end

  assign ack_o       = (r_state == ACK);
  assign dat_o       = r_datO;
  assign gpia_stb_o  = r_stb;
  assign gpia_mode_o = r_mode;
  assign gpia_d_o    = r_d;

endmodule

// File: tb/tb_gpia_wb_port.sv
// ---------------------------------------------------------------------------
// tb_gpia_wb_port
//
// Self-checking bench for gpia_wb_port (NBYTES=2, ADR_W=4). A small model of
// the downstream GPIA byte registers is driven by the DUT's strobe, mode and
// data outputs. Expected read data comes from a separate transaction-level
// reference that applies each write's mode rule to its own copy of the bytes.
// Build with +define+GPIA_WB_INPUT_EN to also exercise the input pins.
// ---------------------------------------------------------------------------
module tb_gpia_wb_port;

  localparam int NB = 2;
  localparam int AW = 4;
`ifdef GPIA_WB_INPUT_EN
  localparam bit HAS_PINS = 1'b1;
`else
  localparam bit HAS_PINS = 1'b0;
`endif

  logic            clk;
  logic            res;
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [7:0]      datIn;
  logic [7:0]      datOut;
  logic            ack;
  logic            gpiaRes;
  logic [1:0]      gpiaMode;
  logic [7:0]      gpiaD;
  logic [NB-1:0]   gpiaStb;
  logic [8*NB-1:0] gpiaQFlat;
  logic [7:0]      pins;

  logic [7:0]      gpiaQ [NB];
  logic [7:0]      refQ [NB];
  logic [7:0]      refPins;

  int vectors;
  int miscompares;

  gpia_wb_port #(
    .NBYTES(NB),
    .ADR_W (AW)
  ) dut (
    .clk_i      (clk),
    .res_i      (res),
    .cyc_i      (cyc),
    .stb_i      (stb),
    .we_i       (we),
    .adr_i      (adr),
    .dat_i      (datIn),
    .dat_o      (datOut),
    .ack_o      (ack),
    .gpia_res_o (gpiaRes),
    .gpia_mode_o(gpiaMode),
    .gpia_d_o   (gpiaD),
    .gpia_stb_o (gpiaStb),
    .gpia_q_i   (gpiaQFlat)
`ifdef GPIA_WB_INPUT_EN
    ,
    .pins_i     (pins)
`endif
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode rule of a GPIA byte: write, set, clear or toggle.
  function automatic logic [7:0] applyMode(input logic [7:0] q, input logic [1:0] mode,
                                           input logic [7:0] d);
    case (mode)
      2'd0:    return d;
      2'd1:    return q | d;
      2'd2:    return q & ~d;
      default: return q ^ d;
    endcase
  endfunction

  // Downstream GPIA byte registers, updated on the edge after their strobe.
  always @(posedge clk) begin
    for (int n = 0; n < NB; n++) begin
      if (gpiaRes) gpiaQ[n] <= 8'h00;
      else if (gpiaStb[n]) gpiaQ[n] <= applyMode(gpiaQ[n], gpiaMode, gpiaD);
    end
  end

  // Flatten the byte array onto the DUT's q bus.
  always_comb begin
    gpiaQFlat = '0;
    for (int n = 0; n < NB; n++) gpiaQFlat[8*n +: 8] = gpiaQ[n];
  end

  // Counts every comparison and reports each mismatch on one line.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // What a read of index idx must return according to the reference.
  function automatic logic [7:0] expectedRead(input int idx);
    if (idx < NB) return refQ[idx];
    if (HAS_PINS && idx == NB) return refPins;
    return 8'h00;
  endfunction

  // One complete classic transfer: request for one cycle, check the ack
  // cycle and the cycle after it, then update the reference bytes.
  task automatic applyStimulus(input bit isWrite, input int idx, input logic [1:0] mode,
                               input logic [7:0] data);
    logic [NB-1:0] expStb;
    logic [7:0]    expRead;
    expStb = '0;
    if (isWrite && idx < NB) expStb[idx] = 1'b1;
    expRead = isWrite ? 8'h00 : expectedRead(idx);
    @(negedge clk);
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = isWrite;
    adr   = {idx[1:0], mode};
    datIn = data;
    @(posedge clk);
    #1;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    checkOutput("ack_high", 32'(ack), 32'd1);
    checkOutput("stb_on_ack", 32'(gpiaStb), 32'(expStb));
    checkOutput("dat_on_ack", 32'(datOut), 32'(expRead));
    if (isWrite && idx < NB) begin
      checkOutput("mode_on_stb", 32'(gpiaMode), 32'(mode));
      checkOutput("d_on_stb", 32'(gpiaD), 32'(data));
    end
    @(posedge clk);
    #1;
    checkOutput("ack_low", 32'(ack), 32'd0);
    checkOutput("stb_low", 32'(gpiaStb), 32'd0);
    checkOutput("dat_low", 32'(datOut), 32'd0);
    if (isWrite && idx < NB) refQ[idx] = applyMode(refQ[idx], mode, data);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    res   = 1'b0;
    cyc   = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    adr   = '0;
    datIn = 8'h00;
    pins  = 8'h00;
    refPins = 8'h00;
    for (int n = 0; n < NB; n++) refQ[n] = 8'h00;

    // Reset held for two cycles, then released.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_stb", 32'(gpiaStb), 32'd0);
    checkOutput("rst_dat", 32'(datOut), 32'd0);
    checkOutput("rst_gpia_res", 32'(gpiaRes), 32'd1);
    @(negedge clk);
    res = 1'b1;
    #1;
    checkOutput("run_gpia_res", 32'(gpiaRes), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("idle_ack", 32'(ack), 32'd0);

    // Plain write then read back.
    applyStimulus(1'b1, 1, 2'd0, 8'h3C);
    applyStimulus(1'b0, 1, 2'd0, 8'h00);

    // Clear, toggle and set modes.
    applyStimulus(1'b1, 0, 2'd0, 8'hFF);
    applyStimulus(1'b1, 0, 2'd2, 8'h3C);
    applyStimulus(1'b0, 0, 2'd0, 8'h00);
    applyStimulus(1'b1, 0, 2'd0, 8'hFF);
    applyStimulus(1'b1, 0, 2'd3, 8'h3C);
    applyStimulus(1'b0, 0, 2'd1, 8'h00);
    applyStimulus(1'b1, 0, 2'd0, 8'h00);
    applyStimulus(1'b1, 0, 2'd1, 8'h3C);
    applyStimulus(1'b0, 0, 2'd2, 8'h00);

    // Master holds a write request for four cycles: ack 1,0,1,0.
    @(negedge clk);
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = 1'b1;
    adr   = {2'd0, 2'd0};
    datIn = 8'h55;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold_ack%0d", c), 32'(ack), (c % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("hold_stb%0d", c), 32'(gpiaStb), (c % 2 == 0) ? 32'd1 : 32'd0);
    end
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    refQ[0] = 8'h55;
    applyStimulus(1'b0, 0, 2'd0, 8'h00);

    // Out-of-range index.
    applyStimulus(1'b1, 3, 2'd0, 8'hA7);
    applyStimulus(1'b0, 3, 2'd0, 8'h00);

    // Reset asserted on the cycle a request is sampled.
    @(negedge clk);
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = 1'b1;
    adr   = {2'd1, 2'd0};
    datIn = 8'h99;
    res   = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstreq_ack", 32'(ack), 32'd0);
    checkOutput("rstreq_stb", 32'(gpiaStb), 32'd0);
    @(negedge clk);
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    res = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstreq_ack2", 32'(ack), 32'd0);
    checkOutput("rstreq_stb2", 32'(gpiaStb), 32'd0);
    for (int n = 0; n < NB; n++) refQ[n] = 8'h00;
    applyStimulus(1'b0, 1, 2'd0, 8'h00);

`ifdef GPIA_WB_INPUT_EN
    // Input pins: not yet visible one edge after the change, visible later.
    @(negedge clk);
    pins = 8'hA5;
    refPins = 8'h00;
    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b0;
    adr = {2'd2, 2'd0};
    @(posedge clk);
    #1;
    cyc = 1'b0;
    stb = 1'b0;
    checkOutput("pins_early", 32'(datOut), 32'h00);
    @(posedge clk);
    #1;
    refPins = 8'hA5;
    applyStimulus(1'b0, 2, 2'd3, 8'h00);
    applyStimulus(1'b1, 2, 2'd0, 8'h12);
    applyStimulus(1'b0, 2, 2'd0, 8'h00);
`endif

    // Randomized transfers against the reference.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 8'($urandom));
    end
    for (int n = 0; n < NB; n++) applyStimulus(1'b0, n, 2'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
